// File: rtl/pattdet_pkg.sv
// Shared types and the round-robin pick helper for the pattern-detector arbiter.
package pattdet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned IDX_W    = PTR_W + 1;

  // First set request at or after ptr, wrapping modulo nreq; 0 when none set.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] req_v,
                                               input logic [PTR_W-1:0]    ptr,
                                               input logic [IDX_W-1:0]    nreq);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      idx = {1'b0, ptr} + IDX_W'(i);
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (IDX_W'(i) < nreq) && req_v[idx[PTR_W-1:0]]) begin
        rr_pick = idx[PTR_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pattdet_engine.sv
// Bit-serial engine: shifts a word MSB-first through a window and counts
// overlapping matches of PAT.
module pattdet_engine #(
  parameter int unsigned        DW      = 8,
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT     = 4'b1010,
  parameter int unsigned        CW      = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          shift_en,
  output logic          last_bit,
  output logic [CW-1:0] match_cnt,
  output logic          match_o
);

  logic [DW-1:0]      sreg;
  logic [PAT_LEN-1:0] win;
  logic [PAT_LEN-1:0] win_nxt;
  logic [CW-1:0]      bitcnt;
  logic               hit;

  // Window after this cycle's shift; comparison only valid once it is full.
  assign win_nxt  = PAT_LEN'({win, sreg[DW-1]});
  assign hit      = (bitcnt >= CW'(PAT_LEN - 1)) && (win_nxt == PAT);
  assign last_bit = (bitcnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sreg      <= '0;
      win       <= '0;
      bitcnt    <= '0;
      match_cnt <= '0;
      match_o   <= 1'b0;
    end else if (load) begin
      sreg      <= load_data;
      win       <= '0;
      bitcnt    <= '0;
      match_cnt <= '0;
      match_o   <= 1'b0;
    end else if (shift_en) begin
      sreg    <= sreg << 1;
      win     <= win_nxt;
      bitcnt  <= bitcnt + CW'(1);
      match_o <= hit;
      if (hit) match_cnt <= match_cnt + CW'(1);
    end else begin
      match_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pattdet_arb_ctrl.sv
// Round-robin arbiter and job FSM sharing one pattern-detection engine
// among NREQ requesters.
module pattdet_arb_ctrl
  import pattdet_pkg::*;
#(
  parameter int unsigned        NREQ    = 4,
  parameter int unsigned        DW      = 8,
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT     = 4'b1010,
  localparam int unsigned       CW      = $clog2(DW + 1),
  localparam int unsigned       OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [CW-1:0]      match_cnt,
  output logic               match_o,
  output logic               busy,
  output logic [OW-1:0]      owner
);

  state_e          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d, owner_d, pick;
  logic [NREQ-1:0] gnt_d, done_d;
  logic            load, shift_en, last_bit;
  logic [DW-1:0]   load_data;

  assign pick      = OW'(rr_pick(MAX_NREQ'(req), PTR_W'(ptr_q), IDX_W'(NREQ)));
  assign load_data = data[32'(pick)*DW +: DW];
  assign shift_en  = (state_q == SHIFT);

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner;
    gnt_d   = '0;
    done_d  = '0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          load    = 1'b1;
          gnt_d   = NREQ'(1) << pick;
          owner_d = pick;
          ptr_d   = (pick == OW'(NREQ - 1)) ? '0 : pick + OW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          done_d  = NREQ'(1) << owner;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      done    <= '0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      done    <= done_d;
      owner   <= owner_d;
      busy    <= (state_d != IDLE);
    end
  end

  pattdet_engine #(
    .DW      (DW),
    .PAT_LEN (PAT_LEN),
    .PAT     (PAT),
    .CW      (CW)
  ) u_engine (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (load),
    .load_data (load_data),
    .shift_en  (shift_en),
    .last_bit  (last_bit),
    .match_cnt (match_cnt),
    .match_o   (match_o)
  );

endmodule

// File: tb/tb_pattdet_arb_ctrl.sv
// Directed bench for pattdet_arb_ctrl: table of single jobs plus
// round-robin, mid-job reset and mid-shift input-change sequences.
module tb_pattdet_arb_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;

  logic               clk = 1'b0;
  logic               rst_b;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [3:0]         match_cnt;
  logic               match_o;
  logic               busy;
  logic [1:0]         owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_after;
    logic [NREQ*DW-1:0] data;
    int                 exp_owner;
    int                 exp_cnt;
    int                 exp_pulses;
  } vec_t;

  vec_t       vecs[5];
  logic [3:0] exp_order[5];

  always #5 clk = ~clk;

  pattdet_arb_ctrl #(
    .NREQ    (NREQ),
    .DW      (DW),
    .PAT_LEN (4),
    .PAT     (4'b1010)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .done      (done),
    .match_cnt (match_cnt),
    .match_o   (match_o),
    .busy      (busy),
    .owner     (owner)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"},   int'(gnt), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_cnt"},   int'(match_cnt), 0);
    chk({tag, "_match"}, int'(match_o), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_owner"}, int'(owner), 0);
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r);
    rst_b = 1'b0;
    req   = r;
    data  = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("rst");
    rst_b = 1'b1;
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt == '0 && lat < 20);
  endtask

  task automatic wait_done(output int n, output int pulses);
    n      = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      n++;
      if (match_o) pulses++;
      if (n == 1) chk("gnt_one_cycle", int'(gnt), 0);
    end while (done == '0 && n < 30);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int lat, n, pulses;
    req  = v.req;
    data = v.data;
    wait_gnt(lat);
    chk({tag, "_gnt_lat"}, lat, 1);
    chk({tag, "_gnt"},     int'(gnt), 1 << v.exp_owner);
    chk({tag, "_owner"},   int'(owner), v.exp_owner);
    chk({tag, "_busy"},    int'(busy), 1);
    wait_done(n, pulses);
    chk({tag, "_done_lat"}, n, DW);
    chk({tag, "_done"},     int'(done), 1 << v.exp_owner);
    chk({tag, "_cnt"},      int'(match_cnt), v.exp_cnt);
    chk({tag, "_pulses"},   pulses, v.exp_pulses);
    req = v.req_after;
    @(negedge clk);
    chk({tag, "_done_clr"}, int'(done), 0);
    chk({tag, "_cnt_hold"}, int'(match_cnt), v.exp_cnt);
    chk({tag, "_idle"},     int'(busy), 0);
  endtask

  initial begin
    int lat, n, pulses, k, c, last_t;
    bit saw;

    // data slice k sits at bits [8k+7:8k]
    vecs[0] = '{4'b0001, 4'b0000, 32'h0000_00AA, 0, 3, 3};
    vecs[1] = '{4'b0010, 4'b0000, 32'h0000_5400, 1, 2, 2};
    vecs[2] = '{4'b0010, 4'b0000, 32'h0000_FF00, 1, 0, 0};
    vecs[3] = '{4'b0011, 4'b0010, 32'h0000_54AA, 0, 3, 3};
    vecs[4] = '{4'b0010, 4'b0000, 32'h0000_54AA, 1, 2, 2};
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_b = 1'b0;
    req   = '0;
    data  = '0;
    do_reset('0);
    for (int i = 0; i < 5; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // All requesters held from reset: grants rotate every DW+2 cycles
    do_reset(4'b1111);
    data   = 32'hAA54_FFAA;
    k      = 0;
    c      = 0;
    last_t = 0;
    while (k < 5 && c < 80) begin
      @(negedge clk);
      c++;
      if (gnt != '0) begin
        chk($sformatf("rr_gnt%0d", k), int'(gnt), int'(exp_order[k]));
        if (k == 0) chk("rr_first_lat", c, 1);
        else        chk($sformatf("rr_gap%0d", k), c - last_t, DW + 2);
        last_t = c;
        k++;
      end
    end
    chk("rr_grants", k, 5);

    // Reset three cycles into a SHIFT aborts the job
    do_reset('0);
    data = 32'h00AA_0000;
    req  = 4'b0100;
    wait_gnt(lat);
    chk("abort_gnt", int'(gnt), 4'b0100);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) saw = 1'b1;
    end
    rst_b = 1'b0;
    req   = '0;
    #1;
    chk_zero_outputs("midrst");
    repeat (3) begin
      @(negedge clk);
      if (done != '0) saw = 1'b1;
    end
    chk("abort_no_done", int'(saw), 0);
    rst_b = 1'b1;
    run_job('{4'b0100, 4'b0000, 32'h00AA_0000, 2, 3, 3}, "post_rst");

    // data2 change and req3 drop during SHIFT are ignored
    do_reset('0);
    data = 32'h0FAA_0000;
    req  = 4'b1100;
    wait_gnt(lat);
    chk("ign_gnt", int'(gnt), 4'b0100);
    repeat (3) @(negedge clk);
    data = 32'hFFFF_0000;
    req  = 4'b0100;
    wait_done(n, pulses);
    chk("ign_done_lat", n, DW - 3);
    chk("ign_done", int'(done), 4'b0100);
    chk("ign_cnt", int'(match_cnt), 3);
    req = '0;
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (gnt != '0) saw = 1'b1;
    end
    chk("ign_no_gnt3", int'(saw), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
